// File: rtl/fetch_pkg.sv
// fetch_pkg: shared sizing and encoding constants for the instruction
// fetch stage and its instruction memory.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 8;
  localparam int DEPTH   = 128;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int CNT_W   = 16;

  // PC value the PC register holds while in reset; it is never fetched.
  localparam logic [PC_W-1:0]    RESET_PC  = 8'hFF;
  // Bubble encoding (MOV r0,r0).
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A00000;
endpackage

// File: rtl/instr_mem.sv
// instr_mem: DEPTH x INSTR_W instruction memory.
//   clk    - write clock (rising edge)
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - combinational read address
//   rdata  - combinational read data
// A write and a read of the same address in one cycle return the old word;
// the new word is visible from the following cycle.
module instr_mem
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: reads the word addressed by PC_Current from the
// instruction memory and registers it with its PC into the IF/ID register.
//   clk, rst              - clock, asynchronous active-high reset
//   PC_Current            - PC from the PC register
//   imem_we/waddr/wdata   - loader write port into the instruction memory
//   flush                 - kill the instruction held in IF/ID
//   id_ready              - decode accepts IF/ID this cycle
//   id_valid/instr/pc     - IF/ID register contents
//   pc_hold               - combinational enable-inhibit for the PC register
//   fetch_fault           - sticky out-of-range fetch flag
//   fetch_count           - saturating count of valid instructions captured
module instr_fetch_stage
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    PC_Current,
  input  logic               imem_we,
  input  logic [ADDR_W-1:0]  imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  input  logic               flush,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic               pc_hold,
  output logic               fetch_fault,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic [INSTR_W-1:0] rdata_p0;
  logic               fetch_ok_p0;
  logic               out_of_range_p0;
  logic               stall;

  logic               vld_p1;
  logic [INSTR_W-1:0] instr_p1;
  logic [PC_W-1:0]    pc_p1;
  logic               fault_q;
  logic [CNT_W-1:0]   count_q;

  instr_mem u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (PC_Current[ADDR_W-1:0]),
    .rdata (rdata_p0)
  );

  // ---- p0: combinational fetch at PC_Current ----
  // Out-of-range PCs must never alias onto a wrapped memory index.
  assign out_of_range_p0 = (PC_Current >= DEPTH_PC) && (PC_Current != RESET_PC);
  assign fetch_ok_p0     = (PC_Current != RESET_PC) && (PC_Current < DEPTH_PC);

  // Bubbles never stall, so id_ready only matters while IF/ID is valid.
  assign stall   = vld_p1 && !id_ready;
  assign pc_hold = stall && !flush;

  // ---- p1: IF/ID register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_INSTR;
      pc_p1    <= RESET_PC;
      fault_q  <= 1'b0;
      count_q  <= '0;
    end else if (flush) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_INSTR;
      pc_p1    <= PC_Current;
    end else if (!stall) begin
      vld_p1   <= fetch_ok_p0;
      instr_p1 <= fetch_ok_p0 ? rdata_p0 : NOP_INSTR;
      pc_p1    <= PC_Current;
      if (fetch_ok_p0) begin
        count_q <= sat_inc(count_q);
      end
      if (out_of_range_p0) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign id_valid    = vld_p1;
  assign id_instr    = instr_p1;
  assign id_pc       = pc_p1;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

  logic        clk;
  logic        rst;
  logic [7:0]  PC_Current;
  logic        imem_we;
  logic [6:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [7:0]  id_pc;
  logic        pc_hold;
  logic        fetch_fault;
  logic [15:0] fetch_count;

  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [128];
  int          errors = 0;
  int          checks = 0;

  localparam logic [31:0] NOP = 32'hE1A00000;

  instr_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .PC_Current  (PC_Current),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .flush       (flush),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .pc_hold     (pc_hold),
    .fetch_fault (fetch_fault),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: a word is delivered when decode accepts a valid
  // IF/ID entry that is not being flushed on the coming edge.
  always @(negedge clk) begin
    if (!rst && id_valid === 1'b1 && id_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got instr %h pc %h, required no delivery", id_instr, id_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_instr", id_instr, e.instr);
        check("sb_pc", {24'h0, id_pc}, {24'h0, e.pc});
      end
    end
  end

  task automatic expect_word(input logic [31:0] instr, input logic [7:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [7:0] pc, input logic rdy, input logic fl);
    PC_Current = pc;
    id_ready   = rdy;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [6:0] a, input logic [31:0] d);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    mdl[a]     = d;
    @(posedge clk);
    #1;
    imem_we    = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, {31'h0, id_valid}, 32'h0);
    check({tag, "_instr"}, id_instr, NOP);
    check({tag, "_pc"}, {24'h0, id_pc}, 32'h0000_00FF);
    check({tag, "_fault"}, {31'h0, fetch_fault}, 32'h0);
    check({tag, "_count"}, {16'h0, fetch_count}, 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    PC_Current = 8'hFF;
    imem_we    = 1'b0;
    imem_waddr = '0;
    imem_wdata = '0;
    flush      = 1'b0;
    id_ready   = 1'b1;
    #2;
    check_reset_vals("rst0");

    // Test 1: reset release, first cycle is a bubble, then PC 00
    load(7'h00, 32'hE3A01005);
    rst = 1'b0;
    step(8'hFF, 1'b1, 1'b0);
    check("t1_bubble_valid", {31'h0, id_valid}, 32'h0);
    check("t1_bubble_fault", {31'h0, fetch_fault}, 32'h0);
    expect_word(32'hE3A01005, 8'h00);
    step(8'h00, 1'b1, 1'b0);
    check("t1_valid", {31'h0, id_valid}, 32'h1);
    check("t1_instr", id_instr, 32'hE3A01005);
    check("t1_count", {16'h0, fetch_count}, 32'h1);
    step(8'hFF, 1'b1, 1'b0);

    // Test 2: sequential fetch with one stall cycle on PC 02
    load(7'h00, 32'h1111_0000);
    load(7'h01, 32'h2222_0001);
    load(7'h02, 32'h3333_0002);
    load(7'h03, 32'h4444_0003);
    expect_word(32'h1111_0000, 8'h00);
    step(8'h00, 1'b1, 1'b0);
    expect_word(32'h2222_0001, 8'h01);
    step(8'h01, 1'b1, 1'b0);
    expect_word(32'h3333_0002, 8'h02);
    step(8'h02, 1'b1, 1'b0);
    PC_Current = 8'h03;
    id_ready   = 1'b0;
    #1;
    check("t2_pc_hold", {31'h0, pc_hold}, 32'h1);
    @(posedge clk);
    #1;
    check("t2_held_pc", {24'h0, id_pc}, 32'h02);
    check("t2_held_instr", id_instr, 32'h3333_0002);
    id_ready = 1'b1;
    #1;
    check("t2_released", {31'h0, pc_hold}, 32'h0);
    expect_word(32'h4444_0003, 8'h03);
    @(posedge clk);
    #1;
    step(8'hFF, 1'b1, 1'b0);
    check("t2_count", {16'h0, fetch_count}, 32'h5);

    // Test 3: flush together with stall while valid
    step(8'h01, 1'b1, 1'b0);
    PC_Current = 8'h02;
    id_ready   = 1'b0;
    flush      = 1'b1;
    #1;
    check("t3_pc_hold", {31'h0, pc_hold}, 32'h0);
    @(posedge clk);
    #1;
    check("t3_valid", {31'h0, id_valid}, 32'h0);
    check("t3_instr", id_instr, NOP);
    check("t3_pc", {24'h0, id_pc}, 32'h02);
    check("t3_count", {16'h0, fetch_count}, 32'h6);
    step(8'hFF, 1'b1, 1'b0);

    // Test 4: out-of-range fetch, sticky fault, cleared by reset
    load(7'h05, 32'h5555_5555);
    step(8'h80, 1'b1, 1'b0);
    check("t4_valid", {31'h0, id_valid}, 32'h0);
    check("t4_instr", id_instr, NOP);
    check("t4_fault", {31'h0, fetch_fault}, 32'h1);
    expect_word(32'h5555_5555, 8'h05);
    step(8'h05, 1'b1, 1'b0);
    check("t4_fault_sticky", {31'h0, fetch_fault}, 32'h1);
    check("t4_count", {16'h0, fetch_count}, 32'h7);
    step(8'hFF, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t4_fault_cleared", {31'h0, fetch_fault}, 32'h0);
    check("t4_count_cleared", {16'h0, fetch_count}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 5: write and fetch of the same address in one cycle
    load(7'h10, 32'h1234_5678);
    imem_we    = 1'b1;
    imem_waddr = 7'h10;
    imem_wdata = 32'hDEAD_BEEF;
    expect_word(32'h1234_5678, 8'h10);
    step(8'h10, 1'b1, 1'b0);
    imem_we = 1'b0;
    mdl[7'h10] = 32'hDEAD_BEEF;
    check("t5_old_word", id_instr, 32'h1234_5678);
    expect_word(32'hDEAD_BEEF, 8'h10);
    step(8'h10, 1'b1, 1'b0);
    check("t5_new_word", id_instr, 32'hDEAD_BEEF);
    step(8'hFF, 1'b1, 1'b0);
    check("t5_count", {16'h0, fetch_count}, 32'h2);

    // Test 6: counter saturation, then async reset mid-run
    for (int i = 0; i < 128; i++) begin
      load(7'(i), 32'hC000_0000 | 32'(i));
    end
    for (int n = 0; n < 65540; n++) begin
      logic [7:0] p;
      p = 8'(n % 128);
      expect_word(mdl[p[6:0]], p);
      step(p, 1'b1, 1'b0);
    end
    check("t6_saturated", {16'h0, fetch_count}, 32'h0000_FFFF);
    PC_Current = 8'h03;
    @(posedge clk);
    #1;
    check("t6_sat_hold", {16'h0, fetch_count}, 32'h0000_FFFF);
    check("t6_valid_before_rst", {31'h0, id_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("t6_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(8'hFF, 1'b1, 1'b0);
    expect_word(32'hC000_0000, 8'h00);
    step(8'h00, 1'b1, 1'b0);
    step(8'hFF, 1'b1, 1'b0);
    check("t6_restart_count", {16'h0, fetch_count}, 32'h1);

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
